// File: rtl/bitstream_decoder_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
// The decoder converts per-channel ones-counts into unipolar and bipolar results.
package bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } decoder_state_t;

  // Count width that holds every value from 0 up to and including length.
  function automatic int count_width(input int length);
    return $clog2(length + 1);
  endfunction

  // Bipolar mapping: a count of c ones over length samples represents 2c - length.
  function automatic int to_bipolar(input int count, input int length);
    return 2 * count - length;
  endfunction

endpackage

// File: rtl/bitstream_decoder_if.sv
// Handshake and data bundle between the decoder, its upstream layer and its consumer.
interface bitstream_decoder_if
  import bitstream_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int STREAM_LENGTH = 256
);
  localparam int COUNT_W = count_width(STREAM_LENGTH);

  logic                                start;
  logic [CHANNELS-1:0]                 stream_in;
  logic                                stream_valid;
  logic                                busy;
  logic                                out_valid;
  logic                                out_ready;
  logic [CHANNELS-1:0][COUNT_W-1:0]    count_out;
  logic signed [CHANNELS-1:0][COUNT_W:0] value_out;

  modport master (
    output start, stream_in, stream_valid, out_ready,
    input  busy, out_valid, count_out, value_out
  );

  modport slave (
    input  start, stream_in, stream_valid, out_ready,
    output busy, out_valid, count_out, value_out
  );

endinterface

// File: rtl/bitstream_decoder_ones_counter.sv
// Per-channel ones accumulator; clear takes priority over counting.
module ones_counter #(
  parameter int COUNT_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic               bit_in,
  output logic [COUNT_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum <= '0;
    end else if (enable && bit_in) begin
      sum <= sum + 1'b1;
    end
  end

endmodule

// File: rtl/bitstream_decoder.sv
// Counts ones on each stochastic input stream over a fixed number of valid samples
// and holds the unipolar count and bipolar value until the consumer accepts them.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int STREAM_LENGTH = 256,
  parameter int COUNT_W       = count_width(STREAM_LENGTH)
) (
  input logic                clk,
  input logic                rst,
  bitstream_decoder_if.slave bus
);

  decoder_state_t                   state_q;
  decoder_state_t                   state_nxt;
  logic [COUNT_W-1:0]               sample_cnt;
  logic [CHANNELS-1:0][COUNT_W-1:0] acc;
  logic [CHANNELS-1:0][COUNT_W-1:0] final_sum;
  logic                             window_clear;
  logic                             sample_en;
  logic                             last_sample;

  // A new window opens from IDLE, or straight out of HOLD when the result is taken.
  assign window_clear = bus.start && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
  assign sample_en    = (state_q == RUN) && bus.stream_valid;
  assign last_sample  = sample_en && (sample_cnt == COUNT_W'(STREAM_LENGTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_sample) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q == RUN);
    bus.out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst || window_clear) begin
      sample_cnt <= '0;
    end else if (sample_en) begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ones_counter #(
      .COUNT_W (COUNT_W)
    ) u_ones_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (window_clear),
      .enable (sample_en),
      .bit_in (bus.stream_in[i]),
      .sum    (acc[i])
    );
  end

  // The final sample is folded in here so the result loads on the same edge.
  always_comb begin
    final_sum = acc;
    for (int i = 0; i < CHANNELS; i++) begin
      final_sum[i] = acc[i] + COUNT_W'(bus.stream_in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.count_out <= '0;
      bus.value_out <= '0;
    end else if (last_sample) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bus.count_out[i] <= final_sum[i];
        bus.value_out[i] <= (COUNT_W + 1)'(to_bipolar(int'(final_sum[i]), STREAM_LENGTH));
      end
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed and randomized checks of bitstream_decoder against a popcount model.
module tb_bitstream_decoder;
  import bitstream_pkg::*;

  localparam int CH = 2;
  localparam int L  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitstream_decoder_if #(.CHANNELS(CH), .STREAM_LENGTH(L)) bus ();

  bitstream_decoder #(
    .CHANNELS      (CH),
    .STREAM_LENGTH (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int exp_cnt [CH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic busy_e, input logic vld_e);
    check({tag, ".busy"}, 32'(bus.busy), 32'(busy_e));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld_e));
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("%s.count%0d", tag, i), 32'(bus.count_out[i]), exp_cnt[i]);
      check($sformatf("%s.value%0d", tag, i), 32'($signed(bus.value_out[i])), 2 * exp_cnt[i] - L);
    end
  endtask

  task automatic check_zero(input string tag);
    check_ctrl(tag, 1'b0, 1'b0);
    for (int i = 0; i < CH; i++) begin
      check($sformatf("%s.count%0d", tag, i), 32'(bus.count_out[i]), 0);
      check($sformatf("%s.value%0d", tag, i), 32'($signed(bus.value_out[i])), 0);
    end
  endtask

  // Pulses start, feeds L valid samples (pattern MSB first) with gaps where gap_mask
  // is set, and leaves the DUT in HOLD. Caller sets out_ready for back-to-back use.
  task automatic run_window(input string tag, input logic [L-1:0] p0, input logic [L-1:0] p1,
                            input logic [31:0] gap_mask, input int stray_start_at,
                            input int exp_vld_cycle);
    logic [L-1:0] pat [CH];
    int cyc;
    int k;
    logic gap;
    pat[0] = p0;
    pat[1] = p1;
    bus.start        = 1'b1;
    bus.stream_valid = 1'b1;
    bus.stream_in    = '1;
    tick();
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check_ctrl({tag, ".start"}, 1'b1, 1'b0);
    cyc = 1;
    k   = 0;
    while (k < L && cyc < 64) begin
      gap           = (cyc <= 32) ? gap_mask[cyc-1] : 1'b0;
      bus.start     = (cyc == stray_start_at);
      bus.out_ready = 1'($urandom_range(0, 1));
      if (gap) begin
        bus.stream_valid = 1'b0;
        bus.stream_in    = CH'($urandom);
      end else begin
        bus.stream_valid = 1'b1;
        for (int i = 0; i < CH; i++) bus.stream_in[i] = pat[i][L-1-k];
        k++;
      end
      tick();
      cyc++;
      if (k < L) check_ctrl({tag, ".run"}, 1'b1, 1'b0);
    end
    bus.start        = 1'b0;
    bus.out_ready    = 1'b0;
    bus.stream_valid = 1'b0;
    check({tag, ".samples"}, k, L);
    check_ctrl({tag, ".hold"}, 1'b0, 1'b1);
    if (exp_vld_cycle > 0) check({tag, ".vld_cycle"}, cyc, exp_vld_cycle);
    for (int i = 0; i < CH; i++) exp_cnt[i] = $countones(pat[i]);
    check_result(tag);
  endtask

  task automatic finish_hold(input string tag);
    bus.out_ready = 1'b1;
    bus.start     = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    check_ctrl({tag, ".idle"}, 1'b0, 1'b0);
    check_result({tag, ".kept"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.stream_in    = '0;
    bus.stream_valid = 1'b0;
    bus.out_ready    = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("idle_after_reset");

    // Scenario 1: constant streams; also a stray 1 sample on the start edge.
    run_window("basic", 8'hFF, 8'h00, 32'h0, -1, 9);
    finish_hold("basic");

    // Scenario 2: mixed pattern gives counts 4 and 3.
    run_window("mixed", 8'b10101010, 8'b11100000, 32'h0, -1, 9);
    finish_hold("mixed");

    // Scenario 3: three gap cycles delay out_valid to cycle 12.
    run_window("gaps", 8'hFF, 8'h00, 32'h0000_002A, -1, 12);

    // Scenario 4: backpressure, start without ready ignored, then back-to-back.
    for (int c = 0; c < 5; c++) begin
      bus.out_ready = 1'b0;
      bus.start     = 1'($urandom_range(0, 1));
      tick();
      check_ctrl("backpressure", 1'b0, 1'b1);
      check_result("backpressure");
    end
    bus.out_ready = 1'b1;
    run_window("b2b", L'($urandom), L'($urandom), 32'h0, -1, 9);
    finish_hold("b2b");

    // Scenario 5: start pulsed mid-run is ignored.
    run_window("stray_start", L'($urandom), L'($urandom), $urandom & $urandom, 3, -1);
    finish_hold("stray_start");

    // Mid-run reset at sample 5 discards everything.
    run_window("pre_rst", 8'hF0, 8'h3C, 32'h0, -1, 9);
    finish_hold("pre_rst");
    bus.start        = 1'b1;
    bus.stream_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      bus.stream_in = CH'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("mid_rst");
    for (int c = 0; c < 3; c++) begin
      bus.stream_valid = 1'b1;
      bus.stream_in    = '1;
      tick();
      check_zero("mid_rst_idle");
    end
    run_window("post_rst", 8'b01101001, 8'b11111110, 32'h0, -1, 9);
    finish_hold("post_rst");

    // Randomized windows, alternately back-to-back.
    for (int w = 0; w < 8; w++) begin
      run_window($sformatf("rand%0d", w), L'($urandom), L'($urandom), $urandom & $urandom, -1, -1);
      if (w % 2 == 0) begin
        bus.out_ready = 1'b1;
        run_window($sformatf("rand%0d_b2b", w), L'($urandom), L'($urandom), $urandom & $urandom, -1, -1);
      end
      finish_hold($sformatf("rand%0d", w));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
